i2s_tx: RTL and testbench

Serial audio transmitter fed by the divided bit clock from `gen_clock`. It samples the generated bit clock in the system clock domain, accepts stereo PCM sample pairs over a valid/ready handshake, and shifts them out MSB-first in standard I2S framing. It sits between the sample source (DAC-side FIFO or tone generator) and the codec pins.

---
 rtl/i2s_tx.sv | 107 ++++++++++
 tb/tb_i2s_tx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx.sv
// i2s_tx: stereo I2S transmitter. bclk_in is sampled as data in the clock_in domain.
// Sample pairs arrive over valid/ready and are shifted out MSB-first.
module i2s_tx #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             bclk_in,
  input  logic [WIDTH-1:0] sample_left,
  input  logic [WIDTH-1:0] sample_right,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             bclk_out,
  output logic             lrclk,
  output logic             sdata,
  output logic             underrun
);

  localparam int unsigned Slots = 2 * WIDTH;
  localparam int unsigned KW    = $clog2(Slots);
  localparam logic [KW-1:0] KLast = KW'(Slots - 1);
  localparam logic [KW-1:0] KHalf = KW'(WIDTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  logic             s1_q, s2_q, s3_q;
  logic             fall_q;
  logic [Slots-1:0] hold_q;
  logic             full_q;
  logic [Slots-1:0] shreg_q;
  logic [KW-1:0]    k_q;
  state_e           state_q;
  logic             sdata_q, lrclk_q, underrun_q;
  logic             capture;
  logic             slot0;

  // Two-flop synchroniser plus delay flop; fall_q acts one cycle after bclk_out falls,
  // so data moves away from the codec's sampling (rising) edge.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= bclk_in;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      fall_q <= s3_q & ~s2_q;
    end
  end

  assign capture = sample_valid & ~full_q;
  // Slot 0 in RUN, or the first frame start out of IDLE once a pair is waiting.
  assign slot0   = fall_q && (k_q == '0) && ((state_q == StRun) || full_q);

  // Holding register: filled by the handshake, emptied by the slot-0 copy.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      full_q <= 1'b0;
    end else if (capture) begin
      hold_q <= {sample_left, sample_right};
      full_q <= 1'b1;
    end else if (slot0) begin
      full_q <= 1'b0;
    end
  end

  // Frame FSM: slot counter, shifter and registered serial outputs.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      k_q        <= '0;
      shreg_q    <= '0;
      sdata_q    <= 1'b0;
      lrclk_q    <= 1'b1;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      if (slot0) begin
        state_q <= StRun;
        sdata_q <= shreg_q[Slots-1];
        lrclk_q <= 1'b0;
        k_q     <= KW'(1);
        if (full_q) begin
          shreg_q <= hold_q;
        end else begin
          shreg_q    <= '0;
          underrun_q <= 1'b1;
        end
      end else if (fall_q && (state_q == StRun)) begin
        sdata_q <= shreg_q[Slots-1];
        shreg_q <= {shreg_q[Slots-2:0], 1'b0};
        lrclk_q <= (k_q >= KHalf);
        k_q     <= (k_q == KLast) ? '0 : k_q + KW'(1);
      end
    end
  end

  assign sample_ready = ~full_q;
  assign bclk_out     = s3_q;
  assign lrclk        = lrclk_q;
  assign sdata        = sdata_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: drives a 16-bit and a 24-bit transmitter from one bit clock and checks
// both against a slot-level frame model every cycle.
module tb_i2s_tx;

  localparam int unsigned W0 = 16;
  localparam int unsigned W1 = 24;

  logic          clock_in = 1'b0;
  logic          reset_n  = 1'b0;
  logic          bclk_in  = 1'b0;
  logic [W0-1:0] l0 = '0, r0 = '0;
  logic [W1-1:0] l1 = '0, r1 = '0;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic          rdy0, bo0, lr0, sd0, un0;
  logic          rdy1, bo1, lr1, sd1, un1;

  i2s_tx #(.WIDTH(W0)) u_dut0 (
    .clock_in(clock_in), .reset_n(reset_n), .bclk_in(bclk_in),
    .sample_left(l0), .sample_right(r0), .sample_valid(v0), .sample_ready(rdy0),
    .bclk_out(bo0), .lrclk(lr0), .sdata(sd0), .underrun(un0)
  );

  i2s_tx #(.WIDTH(W1)) u_dut1 (
    .clock_in(clock_in), .reset_n(reset_n), .bclk_in(bclk_in),
    .sample_left(l1), .sample_right(r1), .sample_valid(v1), .sample_ready(rdy1),
    .bclk_out(bo1), .lrclk(lr1), .sdata(sd1), .underrun(un1)
  );

  always #5 clock_in = ~clock_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]  h = '0;          // bclk_in history; h[2] is the expected bclk_out
  bit          m_full[2], m_run[2], m_cap[2];
  int          m_k[2];
  logic [31:0] m_hl[2], m_hr[2], m_fl[2], m_fr[2];
  logic        e_sd[2], e_lr[2], e_un[2];
  logic        rec_sd[2][512], rec_lr[2][512], rec_un[2][512];
  int          rec_n[2];
  bit          b2b_on = 1'b0;
  int          b2b_caps = 0;
  logic [15:0] q_b2b[$];
  bit          act;

  task automatic model_reset();
    h = '0;
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 1'b0; m_run[i] = 1'b0; m_cap[i] = 1'b0; m_k[i] = 0;
      m_hl[i] = '0; m_hr[i] = '0; m_fl[i] = '0; m_fr[i] = '0;
      e_sd[i] = 1'b0; e_lr[i] = 1'b1; e_un[i] = 1'b0; rec_n[i] = 0;
    end
  endtask

  task automatic record(input int i);
    if (rec_n[i] < 512) begin
      rec_sd[i][rec_n[i]] = e_sd[i];
      rec_lr[i][rec_n[i]] = e_lr[i];
      rec_un[i][rec_n[i]] = e_un[i];
    end
    rec_n[i]++;
  endtask

  // One clock edge of the frame rules: slot 0 sends the previous right LSB and loads
  // the next pair; slots 1..W send the left word, W+1..2W-1 the right word.
  task automatic model_step(input int i, input bit a, input bit v,
                            input logic [31:0] l, input logic [31:0] r);
    int  w;
    int  k;
    bit  cap;
    w = (i == 0) ? int'(W0) : int'(W1);
    cap = v && !m_full[i];
    m_cap[i] = cap;
    e_un[i] = 1'b0;
    if (a) begin
      if (m_k[i] == 0 && (m_run[i] || m_full[i])) begin
        e_sd[i] = m_fr[i][0];
        e_lr[i] = 1'b0;
        if (m_full[i]) begin
          m_fl[i] = m_hl[i];
          m_fr[i] = m_hr[i];
          m_full[i] = 1'b0;
          if (i == 0 && b2b_on) q_b2b.push_back(m_hl[i][15:0]);
        end else begin
          m_fl[i] = '0;
          m_fr[i] = '0;
          e_un[i] = 1'b1;
        end
        m_run[i] = 1'b1;
        m_k[i] = 1;
        record(i);
      end else if (m_run[i]) begin
        k = m_k[i];
        e_sd[i] = (k <= w) ? m_fl[i][w-k] : m_fr[i][2*w-k];
        e_lr[i] = (k >= w);
        m_k[i] = (k == 2 * w - 1) ? 0 : k + 1;
        record(i);
      end
    end
    if (cap) begin
      m_hl[i] = l;
      m_hr[i] = r;
      m_full[i] = 1'b1;
      if (i == 0 && b2b_on) b2b_caps++;
    end
  endtask

  initial begin
    forever begin
      @(posedge clock_in);
      if (!reset_n) begin
        model_reset();
      end else begin
        // Data moves one cycle after bclk_out has fallen.
        act = h[3] && !h[2];
        model_step(0, act, v0, 32'(l0), 32'(r0));
        model_step(1, act, v1, 32'(l1), 32'(r1));
        h = {h[2:0], bclk_in};
      end
    end
  end

  // ---------------- compare process ----------------
  int   viol = 0;
  int   rst_ok = 0;
  logic sd0_p = 1'b0, sd1_p = 1'b0;
  logic bo_p1 = 1'b0, bo_p2 = 1'b0;

  initial begin
    forever begin
      @(negedge clock_in);
      if (!reset_n) begin
        chk("rst_sdata0", 64'(sd0), 64'd0);  chk("rst_sdata1", 64'(sd1), 64'd0);
        chk("rst_lrclk0", 64'(lr0), 64'd1);  chk("rst_lrclk1", 64'(lr1), 64'd1);
        chk("rst_bclk0", 64'(bo0), 64'd0);   chk("rst_bclk1", 64'(bo1), 64'd0);
        chk("rst_ready0", 64'(rdy0), 64'd1); chk("rst_ready1", 64'(rdy1), 64'd1);
        chk("rst_under0", 64'(un0), 64'd0);  chk("rst_under1", 64'(un1), 64'd0);
        rst_ok = 0;
      end else begin
        chk("sdata0", 64'(sd0), 64'(e_sd[0]));   chk("sdata1", 64'(sd1), 64'(e_sd[1]));
        chk("lrclk0", 64'(lr0), 64'(e_lr[0]));   chk("lrclk1", 64'(lr1), 64'(e_lr[1]));
        chk("bclk_out0", 64'(bo0), 64'(h[2]));   chk("bclk_out1", 64'(bo1), 64'(h[2]));
        chk("ready0", 64'(rdy0), 64'(!m_full[0]));
        chk("ready1", 64'(rdy1), 64'(!m_full[1]));
        chk("underrun0", 64'(un0), 64'(e_un[0]));
        chk("underrun1", 64'(un1), 64'(e_un[1]));
        if (rst_ok >= 1) begin
          if (sd0 !== sd0_p && !(bo_p2 && !bo_p1)) viol++;
          if (sd1 !== sd1_p && !(bo_p2 && !bo_p1)) viol++;
        end
        rst_ok++;
      end
      sd0_p = sd0;
      sd1_p = sd1;
      bo_p2 = bo_p1;
      bo_p1 = bo0;
    end
  end

  // ---------------- input driver ----------------
  int          hi_len = 4, lo_len = 4, bc_cnt = 4;
  bit          rand_bclk = 1'b0;
  int          src_mode = 0;         // 0 directed, 1 back-to-back, 2 random
  bit          dl_req[2];
  logic [31:0] dl_l[2], dl_r[2];
  logic [15:0] cnt0 = 16'h0100;
  logic [23:0] cnt1 = 24'h010000;

  initial begin
    forever begin
      @(posedge clock_in);
      #1;
      if (bc_cnt <= 1) begin
        bclk_in = !bclk_in;
        if (rand_bclk) bc_cnt = $urandom_range(2, 5);
        else bc_cnt = bclk_in ? hi_len : lo_len;
      end else begin
        bc_cnt--;
      end
      case (src_mode)
        1: begin
          if (m_cap[0]) cnt0++;
          if (m_cap[1]) cnt1++;
          v0 = 1'b1; l0 = cnt0; r0 = ~cnt0;
          v1 = 1'b1; l1 = cnt1; r1 = ~cnt1;
        end
        2: begin
          v0 = ($urandom_range(0, 15) == 0); l0 = 16'($urandom); r0 = 16'($urandom);
          v1 = ($urandom_range(0, 15) == 0); l1 = 24'($urandom); r1 = 24'($urandom);
        end
        default: begin
          if (dl_req[0] && m_cap[0] && v0) dl_req[0] = 1'b0;
          if (dl_req[1] && m_cap[1] && v1) dl_req[1] = 1'b0;
          v0 = dl_req[0]; l0 = dl_l[0][15:0]; r0 = dl_r[0][15:0];
          v1 = dl_req[1]; l1 = dl_l[1][23:0]; r1 = dl_r[1][23:0];
        end
      endcase
    end
  end

  // ---------------- directed sequence ----------------
  function automatic logic [63:0] pack_sd(input int i, input int from, input int n);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < n; j++) v = {v[62:0], rec_sd[i][from+j]};
    return v;
  endfunction

  function automatic logic [63:0] pack_lr(input int i, input int from, input int n);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < n; j++) v = {v[62:0], rec_lr[i][from+j]};
    return v;
  endfunction

  task automatic wait_rec(input int i, input int n, input string name);
    int t;
    t = 0;
    while (rec_n[i] < n && t < 20000) begin
      @(posedge clock_in);
      t++;
    end
    #2;
    chk(name, 64'(rec_n[i] >= n), 64'd1);
  endtask

  initial begin
    int breaks;
    repeat (6) @(posedge clock_in);
    #1 reset_n = 1'b1;
    repeat (80) @(posedge clock_in);

    // Single frame on both widths, then underrun, then a late pair.
    #2;
    dl_l[0] = 32'h0000A5C3; dl_r[0] = 32'h00000F01; dl_req[0] = 1'b1;
    dl_l[1] = 32'h00800001; dl_r[1] = 32'h005A5A5A; dl_req[1] = 1'b1;
    wait_rec(0, 40, "wait_mid_frame2");
    dl_l[0] = 32'h00001234; dl_r[0] = 32'h00008765; dl_req[0] = 1'b1;
    wait_rec(0, 97, "wait_frame3");
    wait_rec(1, 49, "wait_w24_frame");

    chk("first_slot0_sdata", 64'(rec_sd[0][0]), 64'd0);
    chk("first_slot0_lrclk", 64'(rec_lr[0][0]), 64'd0);
    chk("frame1_sdata", pack_sd(0, 1, 32), 64'hA5C30F01);
    chk("frame1_lrclk", pack_lr(0, 1, 32), 64'h0001FFFE);
    chk("frame1_no_underrun", 64'(rec_un[0][0]), 64'd0);
    chk("frame2_zeros", pack_sd(0, 33, 32), 64'd0);
    chk("frame2_underrun", 64'(rec_un[0][32]), 64'd1);
    chk("frame3_no_underrun", 64'(rec_un[0][64]), 64'd0);
    chk("frame3_late_pair", pack_sd(0, 65, 32), 64'h12348765);
    chk("w24_sdata", pack_sd(1, 1, 48), 64'h8000015A5A5A);
    chk("w24_lrclk", pack_lr(1, 1, 48), 64'h000001FFFFFE);
    chk("w24_left_msb_slot1", 64'(rec_sd[1][1]), 64'd1);
    chk("w24_left_lsb_slot24", 64'(rec_sd[1][24]), 64'd1);

    // Back-to-back with the fastest bit clock.
    hi_len = 2; lo_len = 2;
    b2b_on = 1'b1; b2b_caps = 0; src_mode = 1;
    repeat (1800) @(posedge clock_in);
    #1 src_mode = 0;
    b2b_on = 1'b0;
    chk("b2b_frames", 64'(q_b2b.size() >= 8), 64'd1);
    chk("b2b_rate", 64'(b2b_caps == q_b2b.size() || b2b_caps == q_b2b.size() + 1), 64'd1);
    if (q_b2b.size() > 0) chk("b2b_first", 64'(q_b2b[0]), 64'h0100);
    breaks = 0;
    for (int j = 1; j < q_b2b.size(); j++) if (q_b2b[j] != q_b2b[j-1] + 16'd1) breaks++;
    chk("b2b_sequence", 64'(breaks), 64'd0);

    // Random bit-clock halves and sources, with a mid-frame reset.
    rand_bclk = 1'b1; src_mode = 2;
    repeat (1500) @(posedge clock_in);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_sdata", 64'(sd0), 64'd0);
    chk("async_rst_lrclk", 64'(lr0), 64'd1);
    chk("async_rst_bclk", 64'(bo1), 64'd0);
    chk("async_rst_ready", 64'(rdy1), 64'd1);
    repeat (3) @(posedge clock_in);
    #1 reset_n = 1'b1;
    repeat (2000) @(posedge clock_in);
    #1 src_mode = 0;
    repeat (20) @(posedge clock_in);

    chk("sdata_timing", 64'(viol), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
